// File: rtl/axis_width_down_pkg.sv
// Shared width and count helpers for the AXI4-Stream width down-converter.
// Includes the configuration legality check used at elaboration.
package dwc_pkg;

  function automatic int dwc_clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int dwc_ratio(input int in_w, input int out_w);
    return (out_w > 0) ? (in_w / out_w) : 0;
  endfunction

  // Counter must hold RATIO itself, hence RATIO+1 states.
  function automatic int dwc_cnt_w(input int ratio);
    return dwc_clog2(ratio + 1);
  endfunction

  function automatic bit dwc_cfg_ok(input int in_w, input int out_w);
    return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
  endfunction

endpackage

// File: rtl/axis_width_down_if.sv
// Stream bundle for axis_width_down: wide slave side (s_axis_*) and narrow master side (m_axis_*).
// The tlast pair exists only when AXIS_DWC_TLAST_EN is defined.
interface axis_width_down_if
  import dwc_pkg::*;
#(
  parameter int IN_W  = 1536,
  parameter int OUT_W = 128
) ();
  localparam int CW = dwc_cnt_w(dwc_ratio(IN_W, OUT_W));

  logic [IN_W-1:0]  s_axis_tdata;
  logic [CW-1:0]    s_axis_tnum;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [OUT_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
`ifdef AXIS_DWC_TLAST_EN
  logic             s_axis_tlast;
  logic             m_axis_tlast;
`endif

  // Converter view: consumes the wide stream, produces the narrow one.
  modport slave (
    input  s_axis_tdata, s_axis_tnum, s_axis_tvalid, m_axis_tready,
`ifdef AXIS_DWC_TLAST_EN
    input  s_axis_tlast,
    output m_axis_tlast,
`endif
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  // Environment view: upstream producer and downstream consumer.
  modport master (
    output s_axis_tdata, s_axis_tnum, s_axis_tvalid, m_axis_tready,
`ifdef AXIS_DWC_TLAST_EN
    output s_axis_tlast,
    input  m_axis_tlast,
`endif
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/axis_width_down.sv
// AXI4-Stream width down-converter: one IN_W word out as up to IN_W/OUT_W OUT_W beats.
// Define AXIS_DWC_TLAST_EN to carry tlast through to the final beat of a word.
module axis_width_down
  import dwc_pkg::*;
#(
  parameter int IN_W      = 1536,
  parameter int OUT_W     = 128,
  parameter int MSB_FIRST = 0
) (
  input logic               clk,
  input logic               rst_n,
  axis_width_down_if.slave  bus
);
  localparam int RATIO = dwc_ratio(IN_W, OUT_W);
  localparam int CW    = dwc_cnt_w(RATIO);
  localparam bit CFG_OK = dwc_cfg_ok(IN_W, OUT_W);
  localparam logic [CW-1:0] RATIO_C = CW'(RATIO);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if (!CFG_OK) begin : g_cfg_err
    $error("axis_width_down: IN_W must be a multiple of OUT_W with ratio >= 2");
  end

  logic [IN_W-1:0] hold;
  logic [IN_W-1:0] hold_shift;
  logic [CW-1:0]   rem;
  logic [CW-1:0]   n_eff;
  logic            s_ready;
  logic            s_fire;
  logic            m_fire;

  // Out-of-range counts fall back to a full word rather than emitting nothing.
  always_comb begin
    n_eff = bus.s_axis_tnum;
    if (bus.s_axis_tnum == '0 || bus.s_axis_tnum > RATIO_C) n_eff = RATIO_C;
  end

  // Ready looks through m_axis_tready on the last beat so words chain with no bubble.
  assign s_ready = rst_n && (rem == '0 || (rem == ONE_C && bus.m_axis_tready));
  assign s_fire  = bus.s_axis_tvalid && s_ready;
  assign m_fire  = (rem != '0) && bus.m_axis_tready;

  if (MSB_FIRST != 0) begin : g_msb
    assign hold_shift       = hold << OUT_W;
    assign bus.m_axis_tdata = hold[IN_W-1 -: OUT_W];
  end else begin : g_lsb
    assign hold_shift       = hold >> OUT_W;
    assign bus.m_axis_tdata = hold[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
      rem  <= '0;
    end else if (s_fire) begin
      hold <= bus.s_axis_tdata;
      rem  <= n_eff;
    end else if (m_fire) begin
      hold <= hold_shift;
      rem  <= rem - ONE_C;
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tvalid = (rem != '0);

`ifdef AXIS_DWC_TLAST_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (!rst_n)      last_q <= 1'b0;
    else if (s_fire) last_q <= bus.s_axis_tlast;
  end

  assign bus.m_axis_tlast = last_q && (rem == ONE_C);
`endif

endmodule

// File: tb/tb_axis_width_down.sv
// Directed bench for axis_width_down (IN_W=1536, OUT_W=128): one LSB-first and one MSB-first instance.
module tb_axis_width_down;
  localparam int IN_W  = 1536;
  localparam int OUT_W = 128;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  axis_width_down_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b0 ();
  axis_width_down_if #(.IN_W(IN_W), .OUT_W(OUT_W)) b1 ();

  axis_width_down #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  axis_width_down #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Slice i of the word carries value base+i.
  function automatic logic [IN_W-1:0] mk_word(input int base);
    logic [IN_W-1:0] w;
    w = '0;
    for (int i = 0; i < IN_W / OUT_W; i++) w[i*OUT_W +: OUT_W] = 128'(base + i);
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beat;
    int cyc;
    logic fire;

    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    b0.s_axis_tdata = '0; b0.s_axis_tnum = '0; b0.s_axis_tvalid = 1'b0; b0.m_axis_tready = 1'b1;
    b1.s_axis_tdata = '0; b1.s_axis_tnum = '0; b1.s_axis_tvalid = 1'b0; b1.m_axis_tready = 1'b1;
`ifdef AXIS_DWC_TLAST_EN
    b0.s_axis_tlast = 1'b0;
    b1.s_axis_tlast = 1'b0;
`endif

    // Reset state
    tick(); tick();
    chk("rst_valid0", b0.m_axis_tvalid, 0);
    chk("rst_data0", b0.m_axis_tdata, 0);
    chk("rst_sready0", b0.s_axis_tready, 0);
    chk("rst_valid1", b1.m_axis_tvalid, 0);
    chk("rst_sready1", b1.s_axis_tready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_sready0", b0.s_axis_tready, 1);

    // Basic: full word LSB-first, beats 1..12
    b0.s_axis_tdata = mk_word(1); b0.s_axis_tnum = 4'd0; b0.s_axis_tvalid = 1'b1;
    tick();
    b0.s_axis_tvalid = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("basic_valid", b0.m_axis_tvalid, 1);
      chk("basic_data", b0.m_axis_tdata, 128'(i + 1));
      chk("basic_sready", b0.s_axis_tready, (i == 11) ? 1 : 0);
      tick();
    end
    chk("basic_empty", b0.m_axis_tvalid, 0);

    // Back-to-back: A then B, 24 contiguous beats
    b0.s_axis_tdata = mk_word(32'h100); b0.s_axis_tvalid = 1'b1;
    tick();
    b0.s_axis_tdata = mk_word(32'h200);
    #1;
    for (int k = 0; k < 24; k++) begin
      chk("b2b_valid", b0.m_axis_tvalid, 1);
      chk("b2b_data", b0.m_axis_tdata, (k < 12) ? 128'(32'h100 + k) : 128'(32'h200 + k - 12));
      if (k <= 11) chk("b2b_sready", b0.s_axis_tready, (k == 11) ? 1 : 0);
      tick();
      if (k == 11) b0.s_axis_tvalid = 1'b0;
    end
    chk("b2b_empty", b0.m_axis_tvalid, 0);

    // Short word, MSB-first: tnum=3 then a chained full word
    b1.s_axis_tdata = mk_word(32'h300); b1.s_axis_tnum = 4'd3; b1.s_axis_tvalid = 1'b1;
    tick();
    b1.s_axis_tdata = mk_word(32'h400); b1.s_axis_tnum = 4'd0;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("msb_short_valid", b1.m_axis_tvalid, 1);
      chk("msb_short_data", b1.m_axis_tdata, 128'(32'h300 + 11 - j));
      chk("msb_short_sready", b1.s_axis_tready, (j == 2) ? 1 : 0);
      tick();
    end
    b1.s_axis_tvalid = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk("msb_full_valid", b1.m_axis_tvalid, 1);
      chk("msb_full_data", b1.m_axis_tdata, 128'(32'h400 + 11 - j));
      tick();
    end
    chk("msb_full_empty", b1.m_axis_tvalid, 0);
    b1.s_axis_tdata = mk_word(32'h800); b1.s_axis_tnum = 4'd2; b1.s_axis_tvalid = 1'b1;
    tick();
    b1.s_axis_tvalid = 1'b0;
    chk("msb_two_d0", b1.m_axis_tdata, 128'(32'h80B));
    tick();
    chk("msb_two_d1", b1.m_axis_tdata, 128'(32'h80A));
    tick();
    chk("msb_two_empty", b1.m_axis_tvalid, 0);

    // Backpressure, tnum=15 clamps to a full word
    b0.s_axis_tdata = mk_word(32'h500); b0.s_axis_tnum = 4'd15; b0.s_axis_tvalid = 1'b1;
    tick();
    b0.s_axis_tvalid = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < 12 && cyc < 200) begin
      b0.m_axis_tready = 1'($urandom_range(0, 1));
      #1;
      chk("bp_valid", b0.m_axis_tvalid, 1);
      chk("bp_data", b0.m_axis_tdata, 128'(32'h500 + beat));
      chk("bp_sready", b0.s_axis_tready, (beat == 11 && b0.m_axis_tready) ? 1 : 0);
      fire = b0.m_axis_tready;
      tick();
      if (fire) beat++;
      cyc++;
    end
    chk("bp_count", 128'(beat), 128'(12));
    b0.m_axis_tready = 1'b1;
    #1;
    chk("bp_empty", b0.m_axis_tvalid, 0);

`ifdef AXIS_DWC_TLAST_EN
    // TLAST on the 5th beat only; a following untagged word never asserts it
    b0.s_axis_tdata = mk_word(32'h900); b0.s_axis_tnum = 4'd5; b0.s_axis_tlast = 1'b1; b0.s_axis_tvalid = 1'b1;
    tick();
    b0.s_axis_tvalid = 1'b0; b0.s_axis_tlast = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk("tlast_data", b0.m_axis_tdata, 128'(32'h900 + j));
      chk("tlast_flag", b0.m_axis_tlast, (j == 4) ? 1 : 0);
      tick();
    end
    chk("tlast_empty", b0.m_axis_tvalid, 0);
    b0.s_axis_tdata = mk_word(32'hA00); b0.s_axis_tnum = 4'd0; b0.s_axis_tvalid = 1'b1;
    tick();
    b0.s_axis_tvalid = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk("notlast_flag", b0.m_axis_tlast, 0);
      tick();
    end
`endif

    // Reset mid-word after beat 4
    b0.s_axis_tdata = mk_word(32'h600); b0.s_axis_tnum = 4'd0; b0.s_axis_tvalid = 1'b1;
    tick();
    b0.s_axis_tvalid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("mid_data", b0.m_axis_tdata, 128'(32'h600 + j));
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", b0.m_axis_tvalid, 0);
    chk("mid_rst_data", b0.m_axis_tdata, 0);
    chk("mid_rst_sready", b0.s_axis_tready, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_sready", b0.s_axis_tready, 1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("mid_no_stale", b0.m_axis_tvalid, 0);
    end
    b0.s_axis_tdata = mk_word(32'h700); b0.s_axis_tnum = 4'd2; b0.s_axis_tvalid = 1'b1;
    tick();
    b0.s_axis_tvalid = 1'b0;
    chk("post_rst_d0", b0.m_axis_tdata, 128'(32'h700));
    tick();
    chk("post_rst_d1", b0.m_axis_tdata, 128'(32'h701));
    tick();
    chk("post_rst_empty", b0.m_axis_tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axis_width_down.md
# axis_width_down

Parametrised AXI4-Stream width down-converter: accepts one IN_W-bit word and emits it as up to IN_W/OUT_W consecutive OUT_W-bit beats, selectable LSB- or MSB-first. It provides a per-word beat count for short words and a zero-bubble back-to-back handoff. It sits between the wide systolic-array result buses and the narrow DMA/memory-side streams in the data-route fabric, replacing the fixed 1536→128 converter.

## Interface
- IN_W, 1536, input word width; integer multiple of OUT_W.
- OUT_W, 128, output beat width.
- MSB_FIRST, 0, 0: first beat = bits [OUT_W-1:0]; 1: first beat = bits [IN_W-1:IN_W-OUT_W].
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  IN_W  input word.
- s_axis_tnum  in  CW  number of valid output beats in this word, 1..RATIO; 0 means RATIO. RATIO = IN_W/OUT_W; CW = clog2(RATIO+1).
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet; present only with AXIS_DWC_TLAST_EN.
- m_axis_tdata  out  OUT_W  output beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last beat of a packet; present only with AXIS_DWC_TLAST_EN.

## Operation
- State:
  - data register `hold` (IN_W bits);
  - remaining-beat counter `rem` (CW bits);
  - `last_q` when TLAST is enabled.
- Effective count: n = (s_axis_tnum == 0 || s_axis_tnum > RATIO) ? RATIO : s_axis_tnum.
- m_axis_tvalid = (rem != 0).
- m_axis_tdata:
  - MSB_FIRST=0: hold[OUT_W-1:0].
  - MSB_FIRST=1: hold[IN_W-1:IN_W-OUT_W].
- s_axis_tready = rst_n && (rem == 0 || (rem == 1 && m_axis_tready)). This is a combinational path from m_axis_tready; it is required for zero bubbles.
- An output beat fires when m_axis_tvalid && m_axis_tready:
  - rem decrements;
  - hold shifts by OUT_W: right for MSB_FIRST=0, left for MSB_FIRST=1; zeros fill the vacated bits.
- An input word is accepted when s_axis_tvalid && s_axis_tready:
  - hold <= s_axis_tdata;
  - rem <= n;
  - last_q <= s_axis_tlast.
- Acceptance in the same cycle as the final output beat: the load wins over the shift and decrement; rem becomes the new n, not n-1.
- An input word with tnum=k emits exactly k beats. The remaining RATIO-k slices are discarded.
- While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata and m_axis_tlast are held stable.

## Timing
- Reset (rst_n low at a clock edge):
  - rem=0, hold=0, last_q=0;
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0;
  - s_axis_tready=0 while rst_n is low, and 1 in the first cycle after release.
- Reset mid-word: remaining beats are dropped and no partial beat is emitted afterwards.
- Latency: a word accepted at edge t gives its first beat valid in cycle t+1.
- Throughput: with m_axis_tready held high and input always valid, m_axis_tvalid is continuously high. A full-RATIO word is accepted once every RATIO cycles.
- Full: rem > 1, or rem == 1 with m_axis_tready low. In this state s_axis_tready=0.
- Empty: rem == 0. In this state s_axis_tready=1 and m_axis_tvalid=0.

## Configuration
- AXIS_DWC_TLAST_EN defined:
  - s_axis_tlast and m_axis_tlast ports exist;
  - m_axis_tlast = last_q && (rem == 1), so it asserts only on the final emitted beat of a word whose tlast was set.
- AXIS_DWC_TLAST_EN undefined: both ports and last_q are absent. Data behaviour is identical.

## Structure
- Shared package dwc_pkg holds:
  - the clog2-based count-width function;
  - the RATIO/CW derivation;
  - a localparam check that IN_W % OUT_W == 0 and RATIO >= 2, with an elaboration-time error on violation.
- Single module. No sub-module is natural: the shifter and counter are one tightly coupled register pair.

## Test plan
All scenarios use IN_W=1536, OUT_W=128 (RATIO=12, CW=4).
- Basic: word with slice i = 128'(i+1), tnum=0, m_axis_tready=1 → 12 beats valued 1..12 in cycles t+1..t+12; s_axis_tready high only in cycle t+12.
- Back-to-back: two words A and B continuously valid, m_axis_tready=1 → 24 contiguous valid beats with no gap; B is accepted in the same cycle as A's beat 12.
- Short word with MSB_FIRST=1: tnum=3 → beats are slices 11, 10, 9, then m_axis_tvalid=0; the next word is accepted in the cycle of the 3rd beat.
- Backpressure: m_axis_tready toggles randomly at 50% → beat order preserved; data stable while stalled; s_axis_tready=0 until rem==1 and m_axis_tready is high.
- TLAST (macro on): word with tlast=1, tnum=5 → m_axis_tlast high only on beat 5; a following word with tlast=0 → m_axis_tlast never asserts.
- Reset mid-word: rst_n low for 1 cycle after beat 4 → m_axis_tvalid=0 and m_axis_tdata=0 next cycle, no stale beats afterwards; the next word starts cleanly at slice 0.
